// File: rtl/mem_access_unit_pkg.sv
// Shared MEM-stage definitions: access-size encodings, FSM states and the
// MEM_ACCESS_SUBWORD_EN build switch (byte/halfword support when defined).
package pipeline_defs;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

`ifdef MEM_ACCESS_SUBWORD_EN
    localparam bit SUBWORD_EN = 1'b1;
`else
    localparam bit SUBWORD_EN = 1'b0;
`endif

endpackage

// File: rtl/mem_access_unit_if.sv
// EX/MEM request bundle and MEM result signals between the pipeline and the
// data-memory access unit.
interface mem_access_unit_if;
    // Handshake: a request (read|write, aligned) is accepted in IDLE and must
    // stay stable while stallMEM is high; the access completes in the first
    // cycle stallMEM is low again, when load data is valid.
    logic        memReadMEM;
    logic        memWriteMEM;
    logic [1:0]  accessSizeMEM;
    logic        signedLoadMEM;
    logic [31:0] addressMEM;
    logic [31:0] writeDataMEM;
    logic [31:0] dmReadDataMEM;
    logic        stallMEM;
    logic        misalignMEM;

    modport master (
        output memReadMEM, memWriteMEM, accessSizeMEM, signedLoadMEM,
               addressMEM, writeDataMEM,
        input  dmReadDataMEM, stallMEM, misalignMEM
    );

    modport slave (
        input  memReadMEM, memWriteMEM, accessSizeMEM, signedLoadMEM,
               addressMEM, writeDataMEM,
        output dmReadDataMEM, stallMEM, misalignMEM
    );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering for sub-word accesses: store byte-enables and
// replicated data, load lane extraction/extension, and the misalign flag.
module mem_lane_align
    import pipeline_defs::*;
(
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  byte_en,
    output logic [31:0] lane_data,
    output logic [31:0] load_data,
    output logic        misalign
);
    logic [31:0] shifted;

    always_comb begin
        byte_en   = 4'hF;
        lane_data = store_data;
        load_data = load_word;
        misalign  = 1'b0;
        shifted   = load_word >> {offset, 3'b000};
        case (size)
            SIZE_BYTE: begin
                byte_en   = 4'b0001 << offset;
                lane_data = {4{store_data[7:0]}};
                load_data = {{24{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SIZE_HALF: begin
                misalign  = offset[0];
                byte_en   = offset[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{store_data[15:0]}};
                load_data = {{16{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            default: begin
                misalign = |offset;
            end
        endcase
    end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage data memory with wait-stated access FSM and pipeline stall.
// Define MEM_ACCESS_SUBWORD_EN to enable byte/halfword accesses.
module mem_access_unit
    import pipeline_defs::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_unit_if.slave  bus,
    output state_t            fsm_state
);
    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]   mem [DEPTH_WORDS];
    state_t        state, state_next;
    logic [3:0]    cnt, cnt_next;
    logic [31:0]   rdata;
    logic          stall, do_access, request;
    logic [AW-1:0] word_idx;
    logic [3:0]    byte_en;
    logic [31:0]   lane_data, load_data;
    logic          misalign_raw;
    logic          unused_addr;

    // Upper address bits alias onto the array, so accesses wrap.
    assign word_idx    = bus.addressMEM[AW+1:2];
    assign unused_addr = ^bus.addressMEM[31:AW+2];

`ifdef MEM_ACCESS_SUBWORD_EN
    mem_lane_align u_lane_align (
        .size       (bus.accessSizeMEM),
        .sign_ext   (bus.signedLoadMEM),
        .offset     (bus.addressMEM[1:0]),
        .store_data (bus.writeDataMEM),
        .load_word  (mem[word_idx]),
        .byte_en    (byte_en),
        .lane_data  (lane_data),
        .load_data  (load_data),
        .misalign   (misalign_raw)
    );
`else
    logic unused_cfg;
    assign unused_cfg   = ^{bus.accessSizeMEM, bus.signedLoadMEM};
    assign byte_en      = 4'hF;
    assign lane_data    = bus.writeDataMEM;
    assign load_data    = mem[word_idx];
    assign misalign_raw = |bus.addressMEM[1:0];
`endif

    assign request = (bus.memReadMEM | bus.memWriteMEM) & ~misalign_raw;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        stall      = 1'b0;
        do_access  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (request) begin
                    stall      = 1'b1;
                    cnt_next   = 4'(WAIT_STATES);
                    state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                stall = 1'b1;
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    do_access  = 1'b1;
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Array has no reset; a reset edge suppresses any pending write.
    always_ff @(posedge clk) begin
        if (!reset && do_access && bus.memWriteMEM) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) mem[word_idx][8*k +: 8] <= lane_data[8*k +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= 32'd0;
        end else if (do_access && bus.memReadMEM && !bus.memWriteMEM) begin
            rdata <= load_data;
        end
    end

    assign bus.dmReadDataMEM = rdata;
    assign bus.stallMEM      = stall;
    assign bus.misalignMEM   = (state == ST_IDLE) &&
                               (bus.memReadMEM || bus.memWriteMEM) && misalign_raw;
    assign fsm_state         = state;
endmodule
